// File: rtl/scan_display_mux.sv
// scan_display_mux: registered N-channel display-word selector for the
// 7-segment digit path. The shown channel comes from MODE (manual) or from a
// fixed-rate auto-scan. HOLD freezes everything, and SWITCHED pulses when the
// shown channel changes.
// Optional feature macro: SCAN_BLANK_EN. When defined, F shows BLANK_VAL for
// BLANK_CYCLES cycles, starting on the edge where the channel switches.
module scan_display_mux #(
   parameter int                WIDTH        = 10,
   parameter int                CHANNELS     = 4,
   parameter int                SEL_W        = $clog2(CHANNELS),
   parameter int                SCAN_DIV     = 50000,
   parameter logic [WIDTH-1:0]  BLANK_VAL    = {WIDTH{1'b1}},
   parameter int                BLANK_CYCLES = 4
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic [SEL_W-1:0]          MODE,
   input  logic                      AUTO,
   input  logic                      HOLD,
   input  logic [CHANNELS*WIDTH-1:0] DATA_IN,
   output logic [WIDTH-1:0]          F,
   output logic [SEL_W-1:0]          CHAN,
   output logic                      SWITCHED
);

   // The prescaler needs room for SCAN_DIV-1. The extra headroom bit keeps
   // SCAN_DIV=1 legal, because a zero-width vector is not allowed.
   localparam int                PRE_W      = $clog2(SCAN_DIV + 1);
   localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0]  CHAN_LAST  = SEL_W'(CHANNELS - 1);
   // One bit wider than MODE, so that CHANNELS == 2**SEL_W can be represented.
   localparam logic [SEL_W:0]    CHAN_COUNT = (SEL_W + 1)'(CHANNELS);

   logic [PRE_W-1:0] pre;
   logic [PRE_W-1:0] pre_nxt_p0;
   logic [SEL_W-1:0] nxt_p0;
   logic             mode_ok_p0;
   logic             switch_p0;
   logic [WIDTH-1:0] word_p0;
   logic [WIDTH-1:0] f_nxt_p0;
   logic             blank_f_p0;

   // Decide the next channel and the next prescaler value (HOLD is applied at the register).
   always_comb begin
      pre_nxt_p0 = pre;
      nxt_p0     = CHAN;
      mode_ok_p0 = ({1'b0, MODE} < CHAN_COUNT);
      if (!AUTO) begin
         pre_nxt_p0 = '0;
         if (mode_ok_p0) begin
            nxt_p0 = MODE;
         end
      end else if (pre == PRE_LAST) begin
         pre_nxt_p0 = '0;
         nxt_p0     = (CHAN == CHAN_LAST) ? '0 : SEL_W'(CHAN + 1'b1);
      end else begin
         pre_nxt_p0 = PRE_W'(pre + 1'b1);
      end
      switch_p0 = (nxt_p0 != CHAN);
   end

   // Extract the word of the next channel from the packed input bus.
   always_comb begin
      word_p0 = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (nxt_p0 == SEL_W'(k)) begin
            word_p0 = DATA_IN[k*WIDTH +: WIDTH];
         end
      end
   end

`ifdef SCAN_BLANK_EN
   localparam int             BLK_W    = $clog2(BLANK_CYCLES + 1);
   localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYCLES);
   localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

   logic [BLK_W-1:0] blank_cnt;
   logic [BLK_W-1:0] blank_nxt_p0;

   // Blanking starts on the switch edge. It continues while more than one count remains.
   always_comb begin
      blank_nxt_p0 = blank_cnt;
      blank_f_p0   = 1'b0;
      if (switch_p0) begin
         blank_nxt_p0 = BLK_LOAD;
         blank_f_p0   = 1'b1;
      end else if (blank_cnt != '0) begin
         blank_nxt_p0 = BLK_W'(blank_cnt - 1'b1);
         blank_f_p0   = (blank_cnt != BLK_ONE);
      end
   end

   // Blank counter register. HOLD freezes it, and reset clears it.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         blank_cnt <= '0;
      end else if (!HOLD) begin
         blank_cnt <= blank_nxt_p0;
      end
   end
`else
   // Without the blanking feature, F always shows the selected word.
   always_comb begin
      blank_f_p0 = 1'b0;
   end
`endif

   // Choose between the selected word and the blank pattern for the output register.
   always_comb begin
      f_nxt_p0 = blank_f_p0 ? BLANK_VAL : word_p0;
   end

   // ---- stage boundary: selection -> registered outputs ----
   // Output and scan-state registers. Priority is reset, then HOLD, then update.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         F        <= '0;
         CHAN     <= '0;
         SWITCHED <= 1'b0;
         pre      <= '0;
      end else if (HOLD) begin
         SWITCHED <= 1'b0;
      end else begin
         F        <= f_nxt_p0;
         CHAN     <= nxt_p0;
         SWITCHED <= switch_p0;
         pre      <= pre_nxt_p0;
      end
   end

endmodule

// File: tb/tb_scan_display_mux.sv
// Testbench for scan_display_mux. It drives two instances from shared inputs:
// A uses CHANNELS=5 and SCAN_DIV=3, and includes illegal MODE codes.
// B uses CHANNELS=4, SCAN_DIV=1 and BLANK_CYCLES=1.
// A reference model, written from the behavioural rules, tracks both instances.
module tb_scan_display_mux;

   localparam logic [9:0] BLANKV = 10'h3FF;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        auto_en = 1'b0;
   logic        hold = 1'b0;
   logic [2:0]  mode = '0;
   logic [49:0] data = '0;

   logic [9:0]  f_a, f_b;
   logic [2:0]  chan_a;
   logic [1:0]  chan_b;
   logic        sw_a, sw_b;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   scan_display_mux #(
      .WIDTH(10), .CHANNELS(5), .SEL_W(3), .SCAN_DIV(3),
      .BLANK_VAL(BLANKV), .BLANK_CYCLES(2)
   ) dut_a (
      .CLK(CLK), .RESET_N(rst_n), .MODE(mode), .AUTO(auto_en), .HOLD(hold),
      .DATA_IN(data), .F(f_a), .CHAN(chan_a), .SWITCHED(sw_a)
   );

   scan_display_mux #(
      .WIDTH(10), .CHANNELS(4), .SEL_W(2), .SCAN_DIV(1),
      .BLANK_VAL(BLANKV), .BLANK_CYCLES(1)
   ) dut_b (
      .CLK(CLK), .RESET_N(rst_n), .MODE(mode[1:0]), .AUTO(auto_en), .HOLD(hold),
      .DATA_IN(data[39:0]), .F(f_b), .CHAN(chan_b), .SWITCHED(sw_b)
   );

   // Reference model state. In this model, blank counts the blank cycles still
   // owed after the current one.
   typedef struct {
      int         chan;
      int         pre;
      int         blank;
      logic [9:0] f;
      logic       sw;
   } mst_t;

   mst_t ma, mb;

   function automatic mst_t mstep(mst_t s, logic rstn, logic hld, logic au, int md,
                                  logic [49:0] dat, int nch, int div, int bc);
      mst_t n;
      int   nxt;
      n = s;
      if (!rstn) begin
         n.chan = 0; n.pre = 0; n.blank = 0; n.f = '0; n.sw = 1'b0;
         return n;
      end
      if (hld) begin
         n.sw = 1'b0;
         return n;
      end
      nxt = s.chan;
      if (!au) begin
         n.pre = 0;
         if (md < nch) nxt = md;
      end else begin
         n.pre = (s.pre + 1) % div;
         if (n.pre == 0) nxt = (s.chan + 1) % nch;
      end
      n.sw   = (nxt != s.chan);
      n.chan = nxt;
      n.f    = dat[nxt*10 +: 10];
`ifdef SCAN_BLANK_EN
      if (n.sw) begin
         n.f = BLANKV; n.blank = bc - 1;
      end else if (s.blank > 0) begin
         n.f = BLANKV; n.blank = s.blank - 1;
      end
`endif
      return n;
   endfunction

   initial begin
      ma = '{0, 0, 0, 10'd0, 1'b0};
      mb = '{0, 0, 0, 10'd0, 1'b0};
   end

   always @(posedge CLK) begin
      ma = mstep(ma, rst_n, hold, auto_en, int'(mode), data, 5, 3, 2);
      mb = mstep(mb, rst_n, hold, auto_en, int'(mode[1:0]), {10'd0, data[39:0]}, 4, 1, 1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 3'd5; auto_en = 1'b0; hold = 1'b0;
      data = {$urandom, $urandom};
      tick(); tick();
      total++;
      if ({f_a, chan_a, sw_a} !== 14'd0) begin
         bad++;
         $display("FAIL reset_a: got f=%h chan=%0d sw=%b want 0/0/0", f_a, chan_a, sw_a);
      end
      total++;
      if ({f_b, chan_b, sw_b} !== 13'd0) begin
         bad++;
         $display("FAIL reset_b: got f=%h chan=%0d sw=%b want 0/0/0", f_b, chan_b, sw_b);
      end
      rst_n = 1'b1; mode = 3'd2;
      tick();
      total++;
`ifdef SCAN_BLANK_EN
      if ({f_a, chan_a, sw_a} !== {BLANKV, 3'd2, 1'b1}) begin
`else
      if ({f_a, chan_a, sw_a} !== {data[29:20], 3'd2, 1'b1}) begin
`endif
         bad++;
         $display("FAIL release_a: got f=%h chan=%0d sw=%b want chan=2 sw=1 word2=%h", f_a, chan_a, sw_a, data[29:20]);
      end
      tick();
      total++;
      if (sw_a !== 1'b0 || chan_a !== 3'd2) begin
         bad++;
         $display("FAIL release_pulse_a: got chan=%0d sw=%b want chan=2 sw=0", chan_a, sw_a);
      end
   endtask

   task automatic test_manual();
      int pulses;
      pulses = 0;
      auto_en = 1'b0; hold = 1'b0;
      for (int m = 0; m < 4; m++) begin
         mode = 3'(m);
         for (int e = 0; e < 3; e++) begin
            tick();
            if (sw_a === 1'b1) pulses++;
            total++;
            if ({f_a, chan_a, sw_a} !== {ma.f, 3'(ma.chan), ma.sw}) begin
               bad++;
               $display("FAIL manual_a m=%0d e=%0d: got f=%h chan=%0d sw=%b want f=%h chan=%0d sw=%b",
                        m, e, f_a, chan_a, sw_a, ma.f, ma.chan, ma.sw);
            end
            total++;
            if ({f_b, chan_b, sw_b} !== {mb.f, 2'(mb.chan), mb.sw}) begin
               bad++;
               $display("FAIL manual_b m=%0d e=%0d: got f=%h chan=%0d sw=%b want f=%h chan=%0d sw=%b",
                        m, e, f_b, chan_b, sw_b, mb.f, mb.chan, mb.sw);
            end
         end
`ifndef SCAN_BLANK_EN
         total++;
         if (f_a !== data[m*10 +: 10]) begin
            bad++;
            $display("FAIL manual_word m=%0d: got f=%h want %h", m, f_a, data[m*10 +: 10]);
         end
`endif
      end
      total++;
      if (pulses != 4) begin
         bad++;
         $display("FAIL manual_pulses: got %0d want 4", pulses);
      end
   endtask

   task automatic test_auto_wrap();
      logic [2:0] want_c;
      auto_en = 1'b0; hold = 1'b0; mode = 3'd4;
      tick(); tick(); tick();
      auto_en = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         want_c = (e < 3) ? 3'd4 : ((e < 6) ? 3'd0 : 3'd1);
         total++;
         if (chan_a !== want_c || sw_a !== (e == 3 || e == 6)) begin
            bad++;
            $display("FAIL auto_wrap e=%0d: got chan=%0d sw=%b want chan=%0d sw=%b",
                     e, chan_a, sw_a, want_c, (e == 3 || e == 6));
         end
         total++;
         if ({f_b, chan_b, sw_b} !== {mb.f, 2'(mb.chan), mb.sw}) begin
            bad++;
            $display("FAIL auto_b e=%0d: got f=%h chan=%0d sw=%b want f=%h chan=%0d sw=%b",
                     e, f_b, chan_b, sw_b, mb.f, mb.chan, mb.sw);
         end
      end
   endtask

   task automatic test_hold();
      logic [9:0] f0;
      logic [2:0] c0;
      auto_en = 1'b1;
      tick();
      f0 = f_a; c0 = chan_a;
      hold = 1'b1;
      for (int e = 0; e < 10; e++) begin
         data = {$urandom, $urandom};
         tick();
         total++;
         if (f_a !== f0 || chan_a !== c0 || sw_a !== 1'b0) begin
            bad++;
            $display("FAIL hold e=%0d: got f=%h chan=%0d sw=%b want f=%h chan=%0d sw=0",
                     e, f_a, chan_a, sw_a, f0, c0);
         end
      end
      hold = 1'b0;
      tick();
      total++;
      if (chan_a !== c0 || sw_a !== 1'b0) begin
         bad++;
         $display("FAIL hold_resume1: got chan=%0d sw=%b want chan=%0d sw=0", chan_a, sw_a, c0);
      end
      tick();
      total++;
      if (chan_a !== 3'((c0 + 1) % 5) || sw_a !== 1'b1) begin
         bad++;
         $display("FAIL hold_resume2: got chan=%0d sw=%b want chan=%0d sw=1", chan_a, sw_a, (c0 + 1) % 5);
      end
   endtask

   task automatic test_illegal_mode();
      auto_en = 1'b0; hold = 1'b0; mode = 3'd1;
      tick(); tick(); tick();
      for (int m = 5; m < 8; m++) begin
         mode = 3'(m);
         tick();
         total++;
         if (chan_a !== 3'd1 || sw_a !== 1'b0 || f_a !== data[19:10]) begin
            bad++;
            $display("FAIL illegal_mode m=%0d: got f=%h chan=%0d sw=%b want f=%h chan=1 sw=0",
                     m, f_a, chan_a, sw_a, data[19:10]);
         end
      end
      data[19:10] = ~data[19:10];
      #1;
      total++;
      if (f_a === data[19:10]) begin
         bad++;
         $display("FAIL data_latency_early: got f=%h before the edge, want old word", f_a);
      end
      tick();
      total++;
      if (f_a !== data[19:10]) begin
         bad++;
         $display("FAIL data_latency: got f=%h want %h", f_a, data[19:10]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst_n   = ($urandom_range(0, 99) >= 3);
         hold    = ($urandom_range(0, 99) < 20);
         if ($urandom_range(0, 9) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 3) == 0) mode = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) data = {$urandom, $urandom};
         tick();
         total++;
         if ({f_a, chan_a, sw_a} !== {ma.f, 3'(ma.chan), ma.sw}) begin
            bad++;
            $display("FAIL rand_a c=%0d: got f=%h chan=%0d sw=%b want f=%h chan=%0d sw=%b",
                     c, f_a, chan_a, sw_a, ma.f, ma.chan, ma.sw);
         end
         total++;
         if ({f_b, chan_b, sw_b} !== {mb.f, 2'(mb.chan), mb.sw}) begin
            bad++;
            $display("FAIL rand_b c=%0d: got f=%h chan=%0d sw=%b want f=%h chan=%0d sw=%b",
                     c, f_b, chan_b, sw_b, mb.f, mb.chan, mb.sw);
         end
      end
      rst_n = 1'b1; hold = 1'b0;
   endtask

`ifdef SCAN_BLANK_EN
   task automatic test_blank();
      auto_en = 1'b0; hold = 1'b0; mode = 3'd0;
      tick(); tick(); tick();
      mode = 3'd1;
      for (int e = 0; e < 3; e++) begin
         tick();
         total++;
         if (f_a !== ((e < 2) ? BLANKV : data[19:10]) || chan_a !== 3'd1) begin
            bad++;
            $display("FAIL blank e=%0d: got f=%h chan=%0d want f=%h chan=1",
                     e, f_a, chan_a, (e < 2) ? BLANKV : data[19:10]);
         end
      end
      mode = 3'd2;
      tick();
      rst_n = 1'b0;
      tick();
      total++;
      if (f_a !== 10'd0 || chan_a !== 3'd0 || sw_a !== 1'b0) begin
         bad++;
         $display("FAIL blank_reset: got f=%h chan=%0d sw=%b want 0/0/0", f_a, chan_a, sw_a);
      end
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_manual();
      test_auto_wrap();
      test_hold();
      test_illegal_mode();
`ifdef SCAN_BLANK_EN
      test_blank();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
